// File: rtl/rgb_lut_pkg.sv
// Shared types and constants for the colour-code to RGB lookup controller.
package rgb_lut_pkg;

   localparam int COLOUR_W = 3;
   localparam int RGB_W    = 24;

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   // Each colour-code bit drives one whole channel: bit2=R, bit1=G, bit0=B.
   function automatic logic [RGB_W-1:0] default_rgb(input logic [COLOUR_W-1:0] c);
      return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
   endfunction

endpackage

// File: rtl/rgb_lut_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; pointer names the requester favoured on a tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic ptr_q, ptr_d;

   always_comb begin
      gnt_o = 2'b00;
      ptr_d = ptr_q;
      if (en_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
         endcase
         // Favour the other requester after every read grant.
         if (gnt_o[0])      ptr_d = 1'b1;
         else if (gnt_o[1]) ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/rgb_lut_ctrl.sv
// Loads the default colour table into a single-port BRAM, then arbitrates that
// port between a config writer and two lookup clients, one access per cycle.
module rgb_lut_ctrl
   import rgb_lut_pkg::*;
#(
   parameter int RD_LAT      = 1,
   parameter int NUM_ENTRIES = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [COLOUR_W-1:0]      cfg_addr,
   input  logic [RGB_W-1:0]         cfg_data,
   input  logic [1:0]               rd_valid,
   output logic [1:0]               rd_ready,
   input  logic [2*COLOUR_W-1:0]    rd_colour,
   output logic                     resp_valid,
   output logic                     resp_id,
   output logic [RGB_W-1:0]         resp_rgb,
   output logic                     init_done,
   output logic                     bram_ena,
   output logic                     bram_wea,
   output logic [COLOUR_W-1:0]      bram_addra,
   output logic [RGB_W-1:0]         bram_dina,
   input  logic [RGB_W-1:0]         bram_douta
);

   state_e                state_q, state_d;
   logic [COLOUR_W-1:0]   cnt_q, cnt_d;
   logic                  init_done_q;
   logic                  ena_q, ena_d, wea_q, wea_d;
   logic [COLOUR_W-1:0]   addr_q, addr_d;
   logic [RGB_W-1:0]      din_q, din_d;
   logic [RD_LAT:0]       vld_pipe_q, id_pipe_q;
   logic                  arb_en, rd_acc, rd_id;
   logic [1:0]            gnt;

   // Grants open only once init_done is visible, so nothing is accepted
   // while the table is still being written.
   assign arb_en    = (state_q == RUN) && init_done_q && !cfg_valid;
   assign cfg_ready = (state_q == RUN) && init_done_q && cfg_valid;
   assign rd_ready  = gnt;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (arb_en),
      .req_i (rd_valid),
      .gnt_o (gnt)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ena_d   = 1'b0;
      wea_d   = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      rd_acc  = 1'b0;
      rd_id   = 1'b0;
      case (state_q)
         INIT: begin
            ena_d  = 1'b1;
            wea_d  = 1'b1;
            addr_d = cnt_q;
            din_d  = default_rgb(cnt_q);
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == COLOUR_W'(NUM_ENTRIES - 1)) state_d = RUN;
         end
         RUN: begin
            if (cfg_ready) begin
               ena_d  = 1'b1;
               wea_d  = 1'b1;
               addr_d = cfg_addr;
               din_d  = cfg_data;
            end else if (|gnt) begin
               ena_d  = 1'b1;
               rd_acc = 1'b1;
               rd_id  = gnt[1];
               addr_d = gnt[1] ? rd_colour[COLOUR_W +: COLOUR_W] : rd_colour[0 +: COLOUR_W];
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= INIT;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         ena_q       <= 1'b0;
         wea_q       <= 1'b0;
         addr_q      <= '0;
         din_q       <= '0;
         vld_pipe_q  <= '0;
         id_pipe_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= (state_q == RUN);
         ena_q       <= ena_d;
         wea_q       <= wea_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         // Stage 0 lines up with the registered BRAM address; the last
         // stage lines up with valid douta.
         vld_pipe_q  <= {vld_pipe_q[RD_LAT-1:0], rd_acc};
         id_pipe_q   <= {id_pipe_q[RD_LAT-1:0], rd_id};
      end
   end

   assign bram_ena   = ena_q;
   assign bram_wea   = wea_q;
   assign bram_addra = addr_q;
   assign bram_dina  = din_q;
   assign init_done  = init_done_q;
   assign resp_valid = vld_pipe_q[RD_LAT];
   assign resp_id    = id_pipe_q[RD_LAT];
   assign resp_rgb   = bram_douta;

endmodule

// File: tb/tb_rgb_lut_ctrl.sv
// Scoreboard bench: one controller with RD_LAT=1 and one with RD_LAT=2 share
// the same stimulus, each backed by its own behavioural BRAM.
module tb_rgb_lut_ctrl;

   localparam logic [23:0] DEF [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                                       24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

   typedef struct {
      logic        id;
      logic [23:0] rgb;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic [2:0]  cfg_addr;
   logic [23:0] cfg_data;
   logic [1:0]  rd_valid;
   logic [5:0]  rd_colour;

   logic        cfg_ready1, resp_valid1, resp_id1, init_done1, ena1, wea1;
   logic [1:0]  rd_ready1;
   logic [2:0]  addra1;
   logic [23:0] dina1, douta1, rgb1;
   logic        cfg_ready2, resp_valid2, resp_id2, init_done2, ena2, wea2;
   logic [1:0]  rd_ready2;
   logic [2:0]  addra2;
   logic [23:0] dina2, douta2, douta2_s, rgb2;

   logic [23:0] mem1 [8];
   logic [23:0] mem2 [8];
   logic [23:0] shadow [8];
   exp_t        q1[$], q2[$];
   int          cyc = 0;
   int          n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rgb_lut_ctrl #(.RD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready1),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .rd_valid(rd_valid), .rd_ready(rd_ready1),
      .rd_colour(rd_colour), .resp_valid(resp_valid1), .resp_id(resp_id1), .resp_rgb(rgb1),
      .init_done(init_done1), .bram_ena(ena1), .bram_wea(wea1), .bram_addra(addra1),
      .bram_dina(dina1), .bram_douta(douta1));

   rgb_lut_ctrl #(.RD_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .rd_valid(rd_valid), .rd_ready(rd_ready2),
      .rd_colour(rd_colour), .resp_valid(resp_valid2), .resp_id(resp_id2), .resp_rgb(rgb2),
      .init_done(init_done2), .bram_ena(ena2), .bram_wea(wea2), .bram_addra(addra2),
      .bram_dina(dina2), .bram_douta(douta2));

   always @(posedge clk) begin
      if (ena1) begin
         if (wea1) mem1[addra1] <= dina1;
         else      douta1 <= mem1[addra1];
      end
   end

   always @(posedge clk) begin
      if (ena2) begin
         if (wea2) mem2[addra2] <= dina2;
         else      douta2_s <= mem2[addra2];
      end
      douta2 <= douta2_s;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h @cyc %0d", tag, act, exp, cyc);
      end
   endtask

   // Scoreboard: compare responses due this cycle, then log new handshakes.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q1.delete();
         q2.delete();
         for (int i = 0; i < 8; i++) shadow[i] = DEF[i];
      end else begin
         if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            chk("r1_vld", 32'(resp_valid1), 1);
            chk("r1_id",  32'(resp_id1), 32'(e.id));
            chk("r1_rgb", 32'(rgb1), 32'(e.rgb));
         end else begin
            chk("r1_idle", 32'(resp_valid1), 0);
         end
         if (q2.size() > 0 && q2[0].due == cyc) begin
            e = q2.pop_front();
            chk("r2_vld", 32'(resp_valid2), 1);
            chk("r2_id",  32'(resp_id2), 32'(e.id));
            chk("r2_rgb", 32'(rgb2), 32'(e.rgb));
         end else begin
            chk("r2_idle", 32'(resp_valid2), 0);
         end
         chk("rdy_match", 32'(rd_ready2), 32'(rd_ready1));
         if (cfg_valid && cfg_ready1) shadow[cfg_addr] = cfg_data;
         for (int i = 0; i < 2; i++) begin
            if (rd_valid[i] && rd_ready1[i]) begin
               e.id  = 1'(i);
               e.rgb = shadow[rd_colour[3*i +: 3]];
               e.due = cyc + 2;
               q1.push_back(e);
               e.due = cyc + 3;
               q2.push_back(e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd1(input int id, input logic [2:0] colour);
      logic got;
      got = 1'b0;
      rd_valid[id] = 1'b1;
      rd_colour[3*id +: 3] = colour;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (rd_ready1[id]) got = 1'b1;
         tick();
      end
      chk("rd_hs", 32'(got), 1);
      rd_valid[id] = 1'b0;
   endtask

   initial begin
      logic got;
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
      rd_valid = 2'b01; rd_colour = {3'd0, 3'd4};
      repeat (3) tick();
      @(negedge clk);
      chk("rst_ena",   32'(ena1), 0);
      chk("rst_idone", 32'(init_done1), 0);
      chk("rst_rdy",   32'(rd_ready1), 0);
      chk("rst_rvld",  32'(resp_valid2), 0);
      tick();
      rst_n = 1'b1;

      // Table load; a held lookup must not be accepted before init_done.
      for (int i = 0; i < 8; i++) begin
         tick();
         @(negedge clk);
         chk("init_ena",  32'(ena1), 1);
         chk("init_wea",  32'(wea1), 1);
         chk("init_addr", 32'(addra1), 32'(i));
         chk("init_din",  32'(dina1), 32'(DEF[i]));
         chk("init_din2", 32'(dina2), 32'(DEF[i]));
         chk("init_rdy",  32'(rd_ready1), 0);
         chk("init_idone", 32'(init_done1), 0);
      end
      tick();
      @(negedge clk);
      chk("idone", 32'(init_done1), 1);
      chk("first_gnt", 32'(rd_ready1), 32'b01);
      tick();
      rd_valid = 2'b00;

      repeat (3) tick();
      @(negedge clk);
      chk("idle_ena", 32'(ena1), 0);

      // Serve requester 1 once so the tie below starts with requester 0.
      tick();
      rd1(1, 3'd5);
      repeat (3) tick();

      rd_valid = 2'b11; rd_colour = {3'd6, 3'd1};
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("rr_gnt", 32'(rd_ready1), (j % 2 == 0) ? 32'b01 : 32'b10);
         tick();
      end
      rd_valid = 2'b00;
      repeat (4) tick();

      // Config write collides with a lookup of the same entry.
      cfg_valid = 1'b1; cfg_addr = 3'd2; cfg_data = 24'h123456;
      rd_valid = 2'b01; rd_colour = {3'd0, 3'd2};
      @(negedge clk);
      chk("cfg_rdy",   32'(cfg_ready1), 1);
      chk("cfg_stall", 32'(rd_ready1), 0);
      tick();
      cfg_valid = 1'b0;
      @(negedge clk);
      chk("cfg_wea",  32'(wea1), 1);
      chk("cfg_din",  32'(dina1), 32'h123456);
      chk("rd_after", 32'(rd_ready1), 32'b01);
      tick();
      rd_valid = 2'b00;
      repeat (4) tick();

      // Reset with two lookups in flight.
      rd_valid = 2'b11; rd_colour = {3'd2, 3'd2};
      tick();
      tick();
      rd_valid = 2'b00;
      rst_n = 1'b0;
      #1;
      chk("mid_rvld1", 32'(resp_valid1), 0);
      chk("mid_rvld2", 32'(resp_valid2), 0);
      chk("mid_ena",   32'(ena1), 0);
      chk("mid_idone", 32'(init_done1), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (init_done1) got = 1'b1;
         tick();
      end
      chk("reinit", 32'(got), 1);
      rd1(0, 3'd2);
      repeat (2) tick();
      rd1(1, 3'd7);
      repeat (8) tick();
      chk("drain1", 32'(q1.size()), 0);
      chk("drain2", 32'(q2.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rgb_lut_ctrl.md
Name: rgb_lut_ctrl

Overview:
Sequencer and arbiter for the 8-entry, 24-bit colour-to-RGB block RAM, which has one port and a fixed read latency.
- After reset it loads the default colour table into the BRAM.
- It then shares the single BRAM port between one config-write requester and two read requesters (colour lookups), one access per cycle.
- It sits between the lookup clients and the BRAM IP instance in the colour-converter top level.

Parameters:
RD_LAT, 1, BRAM read latency in cycles, from registered address to valid douta (legal 1..2)
NUM_ENTRIES, 8, table depth; fixed by the 3-bit colour code

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted this cycle
cfg_addr  in  3  entry to overwrite
cfg_data  in  24  new RGB value
rd_valid  in  2  read request, one bit per requester
rd_ready  out  2  read request accepted, one-hot
rd_colour  in  6  colour code, [2:0] for requester 0, [5:3] for requester 1
resp_valid  out  1  lookup result valid (no backpressure)
resp_id  out  1  requester that owns resp_rgb
resp_rgb  out  24  RGB result; equals bram_douta
init_done  out  1  table load complete
bram_ena  out  1  BRAM enable
bram_wea  out  1  BRAM write enable
bram_addra  out  3  BRAM address
bram_dina  out  24  BRAM write data
bram_douta  in  24  BRAM read data

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM to INIT, load counter 0, round-robin pointer 0 (requester 0 favoured first), response pipeline cleared.
- Reset mid-operation: any in-flight response is dropped and the full table load restarts.
- FSM INIT:
  - Each cycle writes entry cnt (bram_ena=1, bram_wea=1, addra=cnt, dina=DEFAULT[cnt]); cnt increments.
  - After writing entry 7, go to RUN; init_done=1 from the next cycle and stays high until reset.
  - cfg_ready and rd_ready stay 0 throughout INIT.
- FSM RUN, combinational grant each cycle:
  - Priority: config > reads.
  - cfg_ready = cfg_valid.
  - If cfg_valid=0 and exactly one rd_valid bit is set, grant that bit.
  - If both rd_valid bits are set, grant the requester not served last; the pointer updates only on a read grant.
  - rd_ready is one-hot or zero; a requester holds valid/colour until ready.
- Access timing: for a handshake in cycle k, the bram_* signals are registered and driven in cycle k+1.
  - bram_ena=0 in cycles with no grant; addra and dina hold their last value.
- Read latency:
  - resp_valid=1 and resp_id are set in cycle k+1+RD_LAT, via a valid/id shift register of depth 1+RD_LAT.
  - Default latency is 2 cycles.
  - Back-to-back reads give a response every cycle.
- Write then read of the same entry in consecutive accepted cycles returns the new data, because BRAM accesses are serialized.
- No simultaneous read and write: a write steals that cycle and pending reads stall.
- resp_rgb = bram_douta; it is qualified by resp_valid and undefined otherwise.

Decomposition:
- Package rgb_lut_pkg holds:
  - localparams COLOUR_W=3, RGB_W=24.
  - State enum {INIT, RUN}.
  - Default table: 0 000000 black, 1 0000FF blue, 2 00FF00 green, 3 00FFFF cyan, 4 FF0000 red, 5 FF00FF magenta, 6 FFFF00 yellow, 7 FFFFFF white.
- One sub-module, rr_arb2: 2-way round-robin arbiter with a pointer, an enable input and one-hot grant.

Test Plan:
- Reset release -> 8 consecutive writes to addra 0..7 with dina=DEFAULT[i], init_done=1 on the 9th cycle, and no ready before then.
- After init, requester 0 reads colour 4 -> resp_valid 2 cycles after the handshake with resp_id=0 and resp_rgb=FF0000.
- Both requesters hold valid (colours 1 and 6) for 4 cycles -> grants alternate 0,1,0,1; responses 0000FF and FFFF00 alternate back-to-back.
- cfg write addr 2 data 123456 in the same cycle as rd_valid[0] for colour 2 -> cfg accepted first, read accepted the next cycle, response 123456.
- rst_n pulsed low while two reads are in flight -> resp_valid stays 0, outputs return to 0 immediately, and the INIT reload restores the default table (colour 2 reads 00FF00).
- Idle cycles in RUN -> bram_ena=0, resp_valid=0; with RD_LAT=2 a lookup of colour 7 gives FFFFFF 3 cycles after the handshake.
